// File: rtl/cond_unit.sv
// cond_unit: ARM condition-check unit for the single-cycle datapath.
// Holds the NZCV flag register, evaluates the instruction condition field
// against the stored flags, and gates the decoder's write enables so that a
// failed condition squashes the instruction.
// Optional feature: define COND_UNIT_SQUASH_CNT_EN to build a saturating
// counter of squashed (failed-condition) instructions on SquashCount.
module cond_unit #(
  parameter logic [3:0] RESET_FLAGS = 4'b0000,
  parameter int         CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             En,
  input  logic [3:0]       Cond,
  input  logic [3:0]       ALUFlags,
  input  logic [1:0]       FlagW,
  input  logic             PCS,
  input  logic             RegW,
  input  logic             MemW,
  input  logic             NoWrite,
  output logic             CondEx,
  output logic             PCSrc,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic [3:0]       Flags,
  output logic [CNT_W-1:0] SquashCount
);

  // ARM condition codes carried in Instr[31:28]
  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_e;

  logic [3:0] flags_q;
  logic [3:0] flags_d;
  logic       flag_n;
  logic       flag_z;
  logic       flag_c;
  logic       flag_v;
  logic       cond_ex;
  logic       active;
  cond_e      cond_code;

  assign flag_n    = flags_q[3];
  assign flag_z    = flags_q[2];
  assign flag_c    = flags_q[1];
  assign flag_v    = flags_q[0];
  assign cond_code = cond_e'(Cond);

  // Condition evaluation uses only the stored flags, never ALUFlags, so there
  // is no combinational path from the ALU back into its own enables.
  always_comb begin
    cond_ex = 1'b1;
    unique case (cond_code)
      COND_EQ: cond_ex = flag_z;
      COND_NE: cond_ex = ~flag_z;
      COND_CS: cond_ex = flag_c;
      COND_CC: cond_ex = ~flag_c;
      COND_MI: cond_ex = flag_n;
      COND_PL: cond_ex = ~flag_n;
      COND_VS: cond_ex = flag_v;
      COND_VC: cond_ex = ~flag_v;
      COND_HI: cond_ex = flag_c & ~flag_z;
      COND_LS: cond_ex = ~flag_c | flag_z;
      COND_GE: cond_ex = (flag_n == flag_v);
      COND_LT: cond_ex = (flag_n != flag_v);
      COND_GT: cond_ex = ~flag_z & (flag_n == flag_v);
      COND_LE: cond_ex = flag_z | (flag_n != flag_v);
      COND_AL: cond_ex = 1'b1;
      COND_NV: cond_ex = 1'b1;
      default: cond_ex = 1'b1;
    endcase
  end

  // An instruction takes effect only when it is valid and its condition passed
  assign active = En & cond_ex;

  assign CondEx   = cond_ex;
  assign PCSrc    = active & PCS;
  assign RegWrite = active & RegW & ~NoWrite;
  assign MemWrite = active & MemW;
  assign Flags    = flags_q;

  // Next flags: NZ and CV halves load independently from the ALU bus
  always_comb begin
    flags_d = flags_q;
    if (active) begin
      if (FlagW[1]) begin
        flags_d[3:2] = ALUFlags[3:2];
      end
      if (FlagW[0]) begin
        flags_d[1:0] = ALUFlags[1:0];
      end
    end
  end

  // Flag register; async reset drops any write that was pending this cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flags_q <= RESET_FLAGS;
    end else begin
      flags_q <= flags_d;
    end
  end

`ifdef COND_UNIT_SQUASH_CNT_EN
  logic [CNT_W-1:0] squash_cnt_q;
  logic [CNT_W-1:0] squash_cnt_d;

  // Count squashed valid instructions, holding at all-ones instead of wrapping
  always_comb begin
    squash_cnt_d = squash_cnt_q;
    if (En && !cond_ex && (squash_cnt_q != {CNT_W{1'b1}})) begin
      squash_cnt_d = squash_cnt_q + CNT_W'(1);
    end
  end

  // Squash counter register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      squash_cnt_q <= '0;
    end else begin
      squash_cnt_q <= squash_cnt_d;
    end
  end

  assign SquashCount = squash_cnt_q;
`else
  assign SquashCount = '0;
`endif

endmodule

// File: tb/tb_cond_unit.sv
// tb_cond_unit: directed self-checking bench for cond_unit.
// Built with a 2-bit squash counter so saturation is reachable quickly;
// counter expectations depend on COND_UNIT_SQUASH_CNT_EN.
module tb_cond_unit;

  localparam int CNT_W = 2;

  logic             clk;
  logic             reset_n;
  logic             En;
  logic [3:0]       Cond;
  logic [3:0]       ALUFlags;
  logic [1:0]       FlagW;
  logic             PCS;
  logic             RegW;
  logic             MemW;
  logic             NoWrite;
  logic             CondEx;
  logic             PCSrc;
  logic             RegWrite;
  logic             MemWrite;
  logic [3:0]       Flags;
  logic [CNT_W-1:0] SquashCount;

  int checks;
  int failures;

  cond_unit #(
    .RESET_FLAGS(4'b0000),
    .CNT_W      (CNT_W)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .En         (En),
    .Cond       (Cond),
    .ALUFlags   (ALUFlags),
    .FlagW      (FlagW),
    .PCS        (PCS),
    .RegW       (RegW),
    .MemW       (MemW),
    .NoWrite    (NoWrite),
    .CondEx     (CondEx),
    .PCSrc      (PCSrc),
    .RegWrite   (RegWrite),
    .MemWrite   (MemWrite),
    .Flags      (Flags),
    .SquashCount(SquashCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Idle all decoder inputs
  task automatic idle();
    En = 1'b0; Cond = 4'b1110; ALUFlags = 4'b0000; FlagW = 2'b00;
    PCS = 1'b0; RegW = 1'b0; MemW = 1'b0; NoWrite = 1'b0;
  endtask

  // Load the flag register through an unconditional full flag write
  task automatic set_flags(input logic [3:0] f);
    En = 1'b1; Cond = 4'b1110; ALUFlags = f; FlagW = 2'b11;
    PCS = 1'b0; RegW = 1'b0; MemW = 1'b0; NoWrite = 1'b1;
    step();
    idle();
    #1;
  endtask

  task automatic test_reset();
    idle();
    reset_n = 1'b0;
    #3;
    checks++;
    if (Flags !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL reset_flags got=%b exp=0000", Flags);
    end
    checks++;
    if (SquashCount !== 2'd0) begin
      failures++;
      $display("[TB] FAIL reset_squash got=%0d exp=0", SquashCount);
    end
    Cond = 4'b0000;
    #1;
    checks++;
    if (CondEx !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_eq got=%b exp=0", CondEx);
    end
    Cond = 4'b0001;
    #1;
    checks++;
    if (CondEx !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_ne got=%b exp=1", CondEx);
    end
    @(negedge clk);
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_cmp_beq();
    En = 1'b1; ALUFlags = 4'b0100; FlagW = 2'b11; Cond = 4'b1110;
    NoWrite = 1'b1; RegW = 1'b1; PCS = 1'b0; MemW = 1'b0;
    #1;
    checks++;
    if (RegWrite !== 1'b0) begin
      failures++;
      $display("[TB] FAIL cmp_regwrite got=%b exp=0", RegWrite);
    end
    checks++;
    if (Flags !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL cmp_no_early_flags got=%b exp=0000", Flags);
    end
    step();
    checks++;
    if (Flags !== 4'b0100) begin
      failures++;
      $display("[TB] FAIL cmp_flags got=%b exp=0100", Flags);
    end
    FlagW = 2'b00; NoWrite = 1'b0; RegW = 1'b0; Cond = 4'b0000; PCS = 1'b1;
    #1;
    checks++;
    if (CondEx !== 1'b1 || PCSrc !== 1'b1) begin
      failures++;
      $display("[TB] FAIL beq_taken got=%b%b exp=11", CondEx, PCSrc);
    end
    idle();
    #1;
  endtask

  task automatic test_partial_update();
    set_flags(4'b1111);
    En = 1'b1; Cond = 4'b1110; FlagW = 2'b10; ALUFlags = 4'b0000;
    step();
    checks++;
    if (Flags !== 4'b0011) begin
      failures++;
      $display("[TB] FAIL partial_nz got=%b exp=0011", Flags);
    end
    FlagW = 2'b01;
    step();
    checks++;
    if (Flags !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL partial_cv got=%b exp=0000", Flags);
    end
    idle();
    #1;
  endtask

  task automatic test_gating();
    En = 1'b1; Cond = 4'b1110; RegW = 1'b1; MemW = 1'b1; PCS = 1'b1; NoWrite = 1'b0;
    #1;
    checks++;
    if ({PCSrc, RegWrite, MemWrite} !== 3'b111) begin
      failures++;
      $display("[TB] FAIL gate_pass got=%b exp=111", {PCSrc, RegWrite, MemWrite});
    end
    idle();
    #1;
  endtask

  task automatic test_squash();
    logic [CNT_W-1:0] exp_cnt;
`ifdef COND_UNIT_SQUASH_CNT_EN
    exp_cnt = 2'd1;
`else
    exp_cnt = 2'd0;
`endif
    En = 1'b1; Cond = 4'b0000; RegW = 1'b1; MemW = 1'b1; PCS = 1'b1;
    FlagW = 2'b11; ALUFlags = 4'b1010;
    #1;
    checks++;
    if ({CondEx, PCSrc, RegWrite, MemWrite} !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL squash_enables got=%b exp=0000", {CondEx, PCSrc, RegWrite, MemWrite});
    end
    step();
    checks++;
    if (Flags !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL squash_flags got=%b exp=0000", Flags);
    end
    checks++;
    if (SquashCount !== exp_cnt) begin
      failures++;
      $display("[TB] FAIL squash_count got=%0d exp=%0d", SquashCount, exp_cnt);
    end
    idle();
    #1;
  endtask

  task automatic test_signed_compare();
    logic [15:0] exp_vec;
    set_flags(4'b1000);
    Cond = 4'b1010; #1; checks++;
    if (CondEx !== 1'b0) begin failures++; $display("[TB] FAIL ge_n1v0 got=%b exp=0", CondEx); end
    Cond = 4'b1011; #1; checks++;
    if (CondEx !== 1'b1) begin failures++; $display("[TB] FAIL lt_n1v0 got=%b exp=1", CondEx); end
    Cond = 4'b1100; #1; checks++;
    if (CondEx !== 1'b0) begin failures++; $display("[TB] FAIL gt_n1v0 got=%b exp=0", CondEx); end
    Cond = 4'b1101; #1; checks++;
    if (CondEx !== 1'b1) begin failures++; $display("[TB] FAIL le_n1v0 got=%b exp=1", CondEx); end
    set_flags(4'b1001);
    Cond = 4'b1010; #1; checks++;
    if (CondEx !== 1'b1) begin failures++; $display("[TB] FAIL ge_n1v1 got=%b exp=1", CondEx); end
    Cond = 4'b1100; #1; checks++;
    if (CondEx !== 1'b1) begin failures++; $display("[TB] FAIL gt_n1v1 got=%b exp=1", CondEx); end
    set_flags(4'b0010);
    Cond = 4'b1000; #1; checks++;
    if (CondEx !== 1'b1) begin failures++; $display("[TB] FAIL hi_c1 got=%b exp=1", CondEx); end
    Cond = 4'b1001; #1; checks++;
    if (CondEx !== 1'b0) begin failures++; $display("[TB] FAIL ls_c1 got=%b exp=0", CondEx); end
    // Full condition sweep: bit i of exp_vec is the expected CondEx for Cond=i
    set_flags(4'b0100);
    exp_vec = 16'hE6A9;
    for (int i = 0; i < 16; i++) begin
      Cond = 4'(i);
      #1;
      checks++;
      if (CondEx !== exp_vec[i]) begin
        failures++;
        $display("[TB] FAIL sweep_z cond=%0d got=%b exp=%b", i, CondEx, exp_vec[i]);
      end
    end
    set_flags(4'b1011);
    exp_vec = 16'hD556;
    for (int i = 0; i < 16; i++) begin
      Cond = 4'(i);
      #1;
      checks++;
      if (CondEx !== exp_vec[i]) begin
        failures++;
        $display("[TB] FAIL sweep_ncv cond=%0d got=%b exp=%b", i, CondEx, exp_vec[i]);
      end
    end
    idle();
    #1;
  endtask

  task automatic test_stall();
    set_flags(4'b0110);
    En = 1'b0; FlagW = 2'b11; ALUFlags = 4'b1001; Cond = 4'b1110;
    PCS = 1'b1; RegW = 1'b1; MemW = 1'b1;
    #1;
    checks++;
    if ({CondEx, PCSrc, RegWrite, MemWrite} !== 4'b1000) begin
      failures++;
      $display("[TB] FAIL stall_enables got=%b exp=1000", {CondEx, PCSrc, RegWrite, MemWrite});
    end
    step();
    checks++;
    if (Flags !== 4'b0110) begin
      failures++;
      $display("[TB] FAIL stall_flags got=%b exp=0110", Flags);
    end
    idle();
    #1;
  endtask

  task automatic test_async_reset();
    set_flags(4'b1111);
    En = 1'b1; Cond = 4'b1110; FlagW = 2'b11; ALUFlags = 4'b0101;
    #1;
    reset_n = 1'b0;
    #1;
    checks++;
    if (Flags !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL async_reset_flags got=%b exp=0000", Flags);
    end
    idle();
    #1;
    reset_n = 1'b1;
    step();
    checks++;
    if (Flags !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL async_reset_discard got=%b exp=0000", Flags);
    end
  endtask

  task automatic test_saturation();
    logic [CNT_W-1:0] exp_cnt;
    int model;
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    idle();
    model = 0;
    En = 1'b1; Cond = 4'b0000;
    for (int k = 0; k < 5; k++) begin
      step();
`ifdef COND_UNIT_SQUASH_CNT_EN
      if (model < 3) model++;
`endif
      exp_cnt = CNT_W'(model);
      checks++;
      if (SquashCount !== exp_cnt) begin
        failures++;
        $display("[TB] FAIL saturation step=%0d got=%0d exp=%0d", k, SquashCount, exp_cnt);
      end
    end
    En = 1'b0;
    step();
    checks++;
    if (SquashCount !== exp_cnt) begin
      failures++;
      $display("[TB] FAIL squash_hold_en0 got=%0d exp=%0d", SquashCount, exp_cnt);
    end
    idle();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset_n = 1'b0;
    idle();
    test_reset();
    test_cmp_beq();
    test_partial_update();
    test_gating();
    test_squash();
    test_signed_compare();
    test_stall();
    test_async_reset();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
